// File: rtl/time_set_controller.sv
// 24-hour BCD time-of-day keeper with a RUN / SET_HOURS / SET_MINUTES editing FSM.
// All outputs are registered, including the per-field blanking for the edit blink.
module time_set_controller #(
  parameter int INIT_HOURS   = 0,
  parameter int INIT_MINUTES = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Mode_Pulse,
  input  logic       i_Inc_Pulse,
  input  logic       i_Tick_1Hz,
  output logic [1:0] o_Hours_Tens,
  output logic [3:0] o_Hours_Ones,
  output logic [2:0] o_Minutes_Tens,
  output logic [3:0] o_Minutes_Ones,
  output logic [2:0] o_Seconds_Tens,
  output logic [3:0] o_Seconds_Ones,
  output logic [1:0] o_Mode,
  output logic       o_Blank_Hours,
  output logic       o_Blank_Minutes
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_SET_HOURS   = 2'b01,
    ST_SET_MINUTES = 2'b10
  } state_e;

  localparam logic [1:0] INIT_HT = 2'(INIT_HOURS / 10);
  localparam logic [3:0] INIT_HO = 4'(INIT_HOURS % 10);
  localparam logic [2:0] INIT_MT = 3'(INIT_MINUTES / 10);
  localparam logic [3:0] INIT_MO = 4'(INIT_MINUTES % 10);

  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  logic [1:0] hrs_tens_q, hrs_tens_d;
  logic [3:0] hrs_ones_q, hrs_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       blank_h_q, blank_h_d;
  logic       blank_m_q, blank_m_d;

  // Hours advance 23 -> 00; returns {tens, ones}.
  function automatic logic [5:0] inc_hours(input logic [1:0] t, input logic [3:0] o);
    if (t == 2'd2 && o == 4'd3) return {2'd0, 4'd0};
    else if (o == 4'd9)         return {t + 2'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  // Minutes advance 59 -> 00; returns {wrap, tens, ones}, wrap marks the hour carry.
  function automatic logic [7:0] inc_minutes(input logic [2:0] t, input logic [3:0] o);
    if (o != 4'd9)      return {1'b0, t, o + 4'd1};
    else if (t != 3'd5) return {1'b0, t + 3'd1, 4'd0};
    else                return {1'b1, 3'd0, 4'd0};
  endfunction

  logic [7:0] min_inc;
  logic [5:0] hrs_inc;

  always_comb begin
    min_inc = inc_minutes(min_tens_q, min_ones_q);
    hrs_inc = inc_hours(hrs_tens_q, hrs_ones_q);
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hrs_tens_d = hrs_tens_q;
    hrs_ones_d = hrs_ones_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    case (state_q)
      ST_RUN: begin
        phase_d = 1'b0;
        if (i_Tick_1Hz) begin
          if (sec_ones_q != 4'd9) begin
            sec_ones_d = sec_ones_q + 4'd1;
          end else begin
            sec_ones_d = 4'd0;
            if (sec_tens_q != 3'd5) begin
              sec_tens_d = sec_tens_q + 3'd1;
            end else begin
              sec_tens_d = 3'd0;
              {min_tens_d, min_ones_d} = min_inc[6:0];
              if (min_inc[7]) {hrs_tens_d, hrs_ones_d} = hrs_inc;
            end
          end
        end
        // A simultaneous tick is still applied above before leaving RUN.
        if (i_Mode_Pulse) state_d = ST_SET_HOURS;
      end

      ST_SET_HOURS: begin
        if (i_Mode_Pulse) begin
          state_d = ST_SET_MINUTES;
          phase_d = 1'b0;
        end else if (i_Inc_Pulse) begin
          {hrs_tens_d, hrs_ones_d} = hrs_inc;
          phase_d = 1'b0;
        end else if (i_Tick_1Hz) begin
          phase_d = ~phase_q;
        end
      end

      ST_SET_MINUTES: begin
        if (i_Mode_Pulse) begin
          state_d    = ST_RUN;
          phase_d    = 1'b0;
          sec_tens_d = 3'd0;
          sec_ones_d = 4'd0;
        end else if (i_Inc_Pulse) begin
          {min_tens_d, min_ones_d} = min_inc[6:0];
          phase_d = 1'b0;
        end else if (i_Tick_1Hz) begin
          phase_d = ~phase_q;
        end
      end

      default: begin
        state_d = ST_RUN;
        phase_d = 1'b0;
      end
    endcase

    blank_h_d = (state_d == ST_SET_HOURS) & phase_d;
    blank_m_d = (state_d == ST_SET_MINUTES) & phase_d;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= ST_RUN;
      phase_q    <= 1'b0;
      hrs_tens_q <= INIT_HT;
      hrs_ones_q <= INIT_HO;
      min_tens_q <= INIT_MT;
      min_ones_q <= INIT_MO;
      sec_tens_q <= 3'd0;
      sec_ones_q <= 4'd0;
      blank_h_q  <= 1'b0;
      blank_m_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hrs_tens_q <= hrs_tens_d;
      hrs_ones_q <= hrs_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      blank_h_q  <= blank_h_d;
      blank_m_q  <= blank_m_d;
    end
  end

  assign o_Hours_Tens    = hrs_tens_q;
  assign o_Hours_Ones    = hrs_ones_q;
  assign o_Minutes_Tens  = min_tens_q;
  assign o_Minutes_Ones  = min_ones_q;
  assign o_Seconds_Tens  = sec_tens_q;
  assign o_Seconds_Ones  = sec_ones_q;
  assign o_Mode          = state_q;
  assign o_Blank_Hours   = blank_h_q;
  assign o_Blank_Minutes = blank_m_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed walk-through of the editing flow plus random
// pulse traffic, checked against a seconds-of-day reference model.
module tb_time_set_controller;

  localparam int INIT_H = 12;
  localparam int INIT_M = 34;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_p = 1'b0, inc_p = 1'b0, tick_p = 1'b0;
  logic [1:0] hrs_t;
  logic [3:0] hrs_o;
  logic [2:0] min_t;
  logic [3:0] min_o;
  logic [2:0] sec_t;
  logic [3:0] sec_o;
  logic [1:0] mode_o;
  logic       blank_h, blank_m;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: time as seconds of day, mode 0/1/2, blink phase.
  int m_sod;
  int m_mode;
  int m_phase;

  time_set_controller #(.INIT_HOURS(INIT_H), .INIT_MINUTES(INIT_M)) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Mode_Pulse   (mode_p),
    .i_Inc_Pulse    (inc_p),
    .i_Tick_1Hz     (tick_p),
    .o_Hours_Tens   (hrs_t),
    .o_Hours_Ones   (hrs_o),
    .o_Minutes_Tens (min_t),
    .o_Minutes_Ones (min_o),
    .o_Seconds_Tens (sec_t),
    .o_Seconds_Ones (sec_o),
    .o_Mode         (mode_o),
    .o_Blank_Hours  (blank_h),
    .o_Blank_Minutes(blank_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sod   = INIT_H * 3600 + INIT_M * 60;
    m_mode  = 0;
    m_phase = 0;
  endtask

  task automatic model_step(input bit md, input bit inc, input bit tk);
    int h, m, s;
    h = m_sod / 3600;
    m = (m_sod / 60) % 60;
    s = m_sod % 60;
    if (m_mode == 0) begin
      if (tk) m_sod = (m_sod + 1) % 86400;
      m_phase = 0;
      if (md) m_mode = 1;
    end else if (md) begin
      if (m_mode == 2) m_sod = h * 3600 + m * 60;
      m_mode  = (m_mode == 1) ? 2 : 0;
      m_phase = 0;
    end else if (inc) begin
      if (m_mode == 1) h = (h + 1) % 24;
      else             m = (m + 1) % 60;
      m_sod   = h * 3600 + m * 60 + s;
      m_phase = 0;
    end else if (tk) begin
      m_phase ^= 1;
    end
  endtask

  task automatic check_all(input string tag);
    int h, m, s;
    h = m_sod / 3600;
    m = (m_sod / 60) % 60;
    s = m_sod % 60;
    chk({tag, ".hrs"},   int'(hrs_t) * 10 + int'(hrs_o), h);
    chk({tag, ".hones"}, int'(hrs_o), h % 10);
    chk({tag, ".min"},   int'(min_t) * 10 + int'(min_o), m);
    chk({tag, ".mones"}, int'(min_o), m % 10);
    chk({tag, ".sec"},   int'(sec_t) * 10 + int'(sec_o), s);
    chk({tag, ".sones"}, int'(sec_o), s % 10);
    chk({tag, ".mode"},  int'(mode_o), m_mode);
    chk({tag, ".blkh"},  int'(blank_h), (m_mode == 1) ? m_phase : 0);
    chk({tag, ".blkm"},  int'(blank_m), (m_mode == 2) ? m_phase : 0);
  endtask

  // Called at posedge+1; applies inputs for one edge and checks the result.
  task automatic drive(input bit md, input bit inc, input bit tk, input string tag);
    mode_p = md; inc_p = inc; tick_p = tk;
    @(posedge clk);
    #1;
    mode_p = 1'b0; inc_p = 1'b0; tick_p = 1'b0;
    model_step(md, inc, tk);
    check_all(tag);
  endtask

  initial begin
    // Plan 1: asynchronous reset, no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst0");
    chk("rst0.ht", int'(hrs_t), 1);
    chk("rst0.mo", int'(min_o), 4);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plan 2: preload 23:59:58 through the set states, then tick through midnight.
    drive(1, 0, 0, "p2.mode");
    for (int i = 0; i < 11; i++) drive(0, 1, 0, "p2.inch");
    drive(1, 0, 0, "p2.mode2");
    for (int i = 0; i < 25; i++) drive(0, 1, 0, "p2.incm");
    drive(1, 0, 0, "p2.run");
    for (int i = 0; i < 58; i++) drive(0, 0, 1, "p2.tick");
    drive(0, 0, 1, "p2.t59");
    chk("p2.235959", int'(sec_t) * 10 + int'(sec_o), 59);
    drive(0, 0, 1, "p2.wrap");
    chk("p2.wrap_h", int'(hrs_t) * 10 + int'(hrs_o), 0);
    chk("p2.wrap_m", int'(min_t) * 10 + int'(min_o), 0);

    // Plan 3: hours 21 -> 22,23,00,01,02, then ticks blink without moving time.
    drive(1, 0, 0, "p3.mode");
    for (int i = 0; i < 21; i++) drive(0, 1, 0, "p3.to21");
    for (int i = 0; i < 5; i++) drive(0, 1, 0, "p3.inc");
    chk("p3.h02", int'(hrs_t) * 10 + int'(hrs_o), 2);
    drive(0, 0, 1, "p3.tk1");
    chk("p3.blk1", int'(blank_h), 1);
    drive(0, 0, 1, "p3.tk2");
    chk("p3.blk2", int'(blank_h), 0);
    drive(0, 0, 1, "p3.tk3");
    chk("p3.blk3", int'(blank_h), 1);

    // Plan 4: hours 05, minutes 59 -> 00 without carry; then Mode+Tick back to RUN.
    for (int i = 0; i < 3; i++) drive(0, 1, 0, "p4.h");
    drive(1, 0, 0, "p4.mode");
    for (int i = 0; i < 59; i++) drive(0, 1, 0, "p4.m");
    drive(0, 1, 0, "p4.mwrap");
    chk("p4.h05", int'(hrs_t) * 10 + int'(hrs_o), 5);
    drive(0, 0, 1, "p4.tk");
    drive(1, 0, 1, "p4.modetick");
    chk("p4.run", int'(mode_o), 0);

    // Plan 5: Mode+Inc in SET_HOURS drops the Inc; Inc ignored in RUN.
    drive(1, 0, 0, "p5.mode");
    drive(1, 1, 0, "p5.modeinc");
    chk("p5.setm", int'(mode_o), 2);
    drive(1, 0, 0, "p5.run");
    for (int i = 0; i < 3; i++) drive(0, 1, 0, "p5.incrun");
    drive(1, 0, 1, "p5.modetick_run");

    // Plan 6: asynchronous reset mid-cycle while blinking in SET_MINUTES.
    drive(1, 0, 0, "p6.setm");
    drive(0, 0, 1, "p6.blink");
    chk("p6.blk", int'(blank_m), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("p6.rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 1, "p6.tick");
    chk("p6.sec1", int'(sec_o), 1);

    // Random traffic, including held levels and simultaneous pulses.
    for (int i = 0; i < 3000; i++) begin
      bit md, inc, tk;
      md  = ($urandom_range(0, 9) == 0);
      inc = ($urandom_range(0, 2) == 0);
      tk  = ($urandom_range(0, 1) == 0);
      drive(md, inc, tk, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
